// File: rtl/gsram_pkg.sv
// Shared types and sizes for the 10x10 x 16-bit grid SRAM and its reader.
package gsram_pkg;

  localparam int unsigned GRID_ROWS = 10;
  localparam int unsigned GRID_COLS = 10;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned COORD_W   = 4;
  localparam int unsigned SUM_W     = 24;

  typedef struct packed {
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
  } coord_t;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic               last;
  } beat_t;

endpackage

// File: rtl/gsram_skid_fifo.sv
// Two-entry FIFO of beats; entry 0 is always the head so outputs come straight from flops.
module gsram_skid_fifo
  import gsram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output beat_t      head,
  output logic [1:0] count
);

  beat_t      e0_q, e1_q;
  logic [1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_q <= push_beat;
          else               e1_q <= push_beat;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          e0_q  <= e1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            e0_q <= e1_q;
            e1_q <= push_beat;
          end else begin
            e0_q <= push_beat;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = e0_q;
  assign count = cnt_q;

endmodule

// File: rtl/gsram_reader.sv
// Row-major sweep of the grid SRAM into a valid/ready stream with coordinates and last flag.
// Optional running sum of delivered cells under GSRAM_READER_SUM_EN.
module gsram_reader #(
  parameter int unsigned ROWS   = 10,
  parameter int unsigned COLS   = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic [3:0]        mem_row,
  output logic [3:0]        mem_col,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_row,
  output logic [3:0]        out_col,
  output logic              out_last
`ifdef GSRAM_READER_SUM_EN
  ,
  output logic [23:0]       sum
`endif
);
  import gsram_pkg::*;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

  state_t     state_q, state_d;
  coord_t     addr_q, addr_d;
  logic       inflight_q;
  coord_t     infl_coord_q;
  logic       infl_last_q;
  beat_t      head, push_beat;
  logic [1:0] count;
  logic       pop_c, done_c, room_c, at_end_c, issue_c;

  assign pop_c    = out_valid & out_ready;
  assign done_c   = pop_c & head.last;
  assign at_end_c = (addr_q.row == COORD_W'(ROWS - 1)) && (addr_q.col == COORD_W'(COLS - 1));
  // Buffered + in-flight after this edge must stay within the two FIFO slots.
  assign room_c   = (3'({1'b0, count}) + 3'(inflight_q) - 3'(pop_c)) < 3'd2;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    issue_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          addr_d  = '0;
        end
      end
      S_SCAN: begin
        if (room_c) begin
          issue_c = 1'b1;
          if (at_end_c) begin
            state_d = S_DRAIN;
          end else if (addr_q.col == COORD_W'(COLS - 1)) begin
            addr_d.col = '0;
            addr_d.row = addr_q.row + COORD_W'(1);
          end else begin
            addr_d.col = addr_q.col + COORD_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (done_c) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      inflight_q   <= 1'b0;
      infl_coord_q <= '0;
      infl_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      inflight_q <= issue_c;
      if (issue_c) begin
        infl_coord_q <= addr_q;
        infl_last_q  <= at_end_c;
      end
    end
  end

  // Read data returns one cycle after issue, alongside its delayed coordinates.
  assign push_beat = '{data: mem_rdata, row: infl_coord_q.row, col: infl_coord_q.col,
                       last: infl_last_q};

  gsram_skid_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_beat (push_beat),
    .pop       (pop_c),
    .head      (head),
    .count     (count)
  );

  assign busy      = (state_q != S_IDLE);
  assign done      = done_c;
  assign mem_we    = 1'b0;
  assign mem_row   = addr_q.row;
  assign mem_col   = addr_q.col;
  assign out_valid = (count != 2'd0);
  assign out_data  = head.data;
  assign out_row   = head.row;
  assign out_col   = head.col;
  assign out_last  = head.last;

`ifdef GSRAM_READER_SUM_EN
  logic             accept_c;
  logic [SUM_W-1:0] sum_q;

  assign accept_c = (state_q == S_IDLE) & start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sum_q <= '0;
    else if (accept_c) sum_q <= '0;
    else if (pop_c)    sum_q <= sum_q + SUM_W'(head.data);
  end

  assign sum = sum_q;
`endif

endmodule

// File: tb/tb_gsram_reader.sv
// Directed bench for gsram_reader with a behavioural grid SRAM; sum checks under GSRAM_READER_SUM_EN.
`timescale 1ns/1ps
module tb_gsram_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, mem_we;
  logic [3:0]  mem_row, mem_col;
  logic [15:0] mem_rdata;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_row, out_col;
  logic        out_last;
`ifdef GSRAM_READER_SUM_EN
  logic [23:0] sum;
`endif

  int checks = 0;
  int errors = 0;
  int idx;
  int cyc;
  bit fill_ff = 1'b0;

  always #5 clk = ~clk;

  gsram_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_we    (mem_we),
    .mem_row   (mem_row),
    .mem_col   (mem_col),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last)
`ifdef GSRAM_READER_SUM_EN
    ,
    .sum       (sum)
`endif
  );

  // Grid SRAM model: mem[r][c] = r*16 + c, or all 0xFFFF; one-cycle read latency.
  always @(posedge clk) mem_rdata <= fill_ff ? 16'hFFFF : {8'h00, mem_row, mem_col};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_data(input int i);
    return fill_ff ? 16'hFFFF : 16'((i / 10) * 16 + (i % 10));
  endfunction

  // One cycle: drive inputs, score any handshake about to happen, then cross the edge.
  task automatic tick(input logic rdy, input logic st);
    int a;
    out_ready = rdy;
    start     = st;
    #1;
    a = int'(mem_row) * 10 + int'(mem_col);
    check("addr_ahead", 32'((a - idx) <= 2), 32'd1);
    if (out_valid && out_ready) begin
      check("beat_data", 32'(out_data), 32'(exp_data(idx)));
      check("beat_row",  32'(out_row),  32'(idx / 10));
      check("beat_col",  32'(out_col),  32'(idx % 10));
      check("beat_last", 32'(out_last), 32'(idx == 99));
      check("beat_done", 32'(done),     32'(idx == 99));
      idx++;
    end else begin
      check("done_low", 32'(done), 32'd0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_sweep(input bit rnd, input int start_at, input int rst_at, output int cycles);
    logic r, st;
    bit   pulsed, aborted;
    pulsed  = 1'b0;
    aborted = 1'b0;
    cycles  = 0;
    while (idx < 100 && cycles < 1000 && !aborted) begin
      if (idx == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_done",     32'(done),      32'd0);
        check("rst_valid",    32'(out_valid), 32'd0);
        check("rst_last",     32'(out_last),  32'd0);
        check("rst_data",     32'(out_data),  32'd0);
        check("rst_out_row",  32'(out_row),   32'd0);
        check("rst_out_col",  32'(out_col),   32'd0);
        check("rst_mem_row",  32'(mem_row),   32'd0);
        check("rst_mem_col",  32'(mem_col),   32'd0);
        #1;
        rst_n   = 1'b1;
        aborted = 1'b1;
      end else begin
        r  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        st = (idx == start_at) && !pulsed;
        pulsed = pulsed | st;
        tick(r, st);
        cycles++;
      end
    end
    if (!aborted) check("sweep_beats", 32'(idx), 32'd100);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    idx       = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",    32'(busy),      32'd0);
    check("reset_valid",   32'(out_valid), 32'd0);
    check("reset_last",    32'(out_last),  32'd0);
    check("reset_data",    32'(out_data),  32'd0);
    check("reset_mem_row", 32'(mem_row),   32'd0);
    check("reset_mem_col", 32'(mem_col),   32'd0);
    check("reset_we",      32'(mem_we),    32'd0);
`ifdef GSRAM_READER_SUM_EN
    check("reset_sum",     32'(sum),       32'd0);
`endif
    rst_n = 1'b1;
    tick(1'b1, 1'b0);

    // Full sweep, out_ready high: latency and 100 consecutive beats.
    idx = 0;
    tick(1'b1, 1'b1);
    check("start_busy",  32'(busy),      32'd1);
    check("start_valid", 32'(out_valid), 32'd0);
    tick(1'b1, 1'b0);
    check("n1_valid",    32'(out_valid), 32'd0);
    tick(1'b1, 1'b0);
    check("n2_valid",    32'(out_valid), 32'd1);
    run_sweep(1'b0, -1, -1, cyc);
    check("sweep_cycles", 32'(cyc),  32'd100);
    check("end_busy",     32'(busy), 32'd0);

    // Restart the cycle after done; random backpressure; stray start at beat 40.
    idx = 0;
    tick(1'b1, 1'b1);
    check("restart_busy", 32'(busy), 32'd1);
    run_sweep(1'b1, 40, -1, cyc);
    check("rnd_end_busy", 32'(busy), 32'd0);

    // Consumer stalled for 20 cycles: exactly two reads issued, head stable.
    idx = 0;
    tick(1'b0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      tick(1'b0, 1'b0);
      if (i >= 2) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_row",   32'(out_row),   32'd0);
        check("stall_col",   32'(out_col),   32'd0);
        check("stall_data",  32'(out_data),  32'd0);
      end
    end
    check("stall_mem_row", 32'(mem_row), 32'd0);
    check("stall_mem_col", 32'(mem_col), 32'd2);
    run_sweep(1'b0, -1, -1, cyc);

    // Reset at beat 57, then a fresh sweep from (0,0).
    idx = 0;
    tick(1'b1, 1'b1);
    run_sweep(1'b0, -1, 57, cyc);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("post_rst_busy",  32'(busy),      32'd0);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    idx = 0;
    tick(1'b1, 1'b1);
    run_sweep(1'b0, -1, -1, cyc);

    // All cells 0xFFFF: sum reaches 100 * 65535 and holds until the next start.
    fill_ff = 1'b1;
    idx = 0;
    tick(1'b1, 1'b1);
    run_sweep(1'b1, -1, -1, cyc);
`ifdef GSRAM_READER_SUM_EN
    check("sum_final", 32'(sum), 32'h0063FF9C);
`endif
    repeat (3) tick(1'b1, 1'b0);
`ifdef GSRAM_READER_SUM_EN
    check("sum_hold", 32'(sum), 32'h0063FF9C);
`endif
    idx = 0;
    tick(1'b1, 1'b1);
`ifdef GSRAM_READER_SUM_EN
    check("sum_clear", 32'(sum), 32'd0);
`endif
    run_sweep(1'b0, -1, -1, cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
